// File: rtl/ram8_burst_master.sv
// Burst initiator for the 8-word x 16-bit RAM8: sequences address/in/load for
// write bursts from a valid/ready stream and read bursts onto a backpressured stream.
module ram8_burst_master #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_start,
    input  logic [2:0]  cmd_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [2:0]  ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    input  logic [15:0] ram_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_READ_OUT  = 2'd3
    } state_t;

    // Final wait count before ram_out is captured; the address has then been
    // stable for READ_LATENCY cycles.
    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    state_t      state_r;
    logic [2:0]  addr_r;
    logic [2:0]  remaining_r;
    logic [1:0]  wait_cnt_r;
    logic [15:0] rd_data_r;
    logic        done_r;

    logic        in_write_s;

    // Handshake and RAM pin decode; load and write-ready are forced low under reset.
    always_comb begin
        in_write_s  = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_load    = 1'b0;
        if (reset) begin
            in_write_s = 1'b0;
            cmd_ready  = 1'b0;
        end else begin
            in_write_s = (state_r == ST_WRITE);
            cmd_ready  = (state_r == ST_IDLE);
        end
        wr_ready = in_write_s;
        ram_load = in_write_s & wr_valid;
    end

    assign rd_valid    = (state_r == ST_READ_OUT);
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign rd_data     = rd_data_r;
    assign ram_address = addr_r;
    assign ram_in      = wr_data;

    // Burst sequencer: command capture, write beats, read wait/capture/present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= 3'd0;
            remaining_r <= 3'd0;
            wait_cnt_r  <= 2'd0;
            rd_data_r   <= 16'd0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_r      <= cmd_start;
                        remaining_r <= cmd_len;
                        wait_cnt_r  <= 2'd0;
                        state_r     <= cmd_write ? ST_WRITE : ST_READ_WAIT;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid) begin
                        if (remaining_r == 3'd0) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            addr_r      <= addr_r + 3'd1;
                            remaining_r <= remaining_r - 3'd1;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 2'd1;
                    if (wait_cnt_r == LAST_WAIT) begin
                        rd_data_r <= ram_out;
                        state_r   <= ST_READ_OUT;
                    end
                end
                ST_READ_OUT: begin
                    // rd_data_r holds until the consumer takes it.
                    if (rd_ready) begin
                        if (remaining_r == 3'd0) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            addr_r      <= addr_r + 3'd1;
                            remaining_r <= remaining_r - 3'd1;
                            wait_cnt_r  <= 2'd0;
                            state_r     <= ST_READ_WAIT;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_burst_master.sv
// Directed bench for ram8_burst_master against a small RAM8 model with a
// one-register read path (two-cycle latency from address to captured data).
module tb_ram8_burst_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_start;
    logic [2:0]  cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] mem [0:7];
    logic [15:0] ram_q;

    ram8_burst_master #(.READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_start(cmd_start), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
        .ram_out(ram_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM8 model: synchronous write, registered read path.
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
        ram_q <= mem[ram_address];
    end
    assign ram_out = ram_q;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1);
    end

    // Offer a command and return just after the edge that accepts it.
    task automatic issue_cmd(input logic w, input logic [2:0] s, input logic [2:0] l, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_write = w; cmd_start = s; cmd_len = l; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (cmd_ready) ok = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_start = 3'd5; cmd_len = 3'd2;
        wr_valid = 1'b0; wr_data = 16'd0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({cmd_ready, busy, done, rd_valid, wr_ready, ram_load, ram_address, rd_data} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b rv=%b wrr=%b load=%b addr=%0d rd=%h exp all 0",
                     cmd_ready, busy, done, rd_valid, wr_ready, ram_load, ram_address, rd_data);
        end
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0;
        #1;
        tests_run++;
        if ({cmd_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_burst();
        logic ok;
        issue_cmd(1'b1, 3'd6, 3'd3, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL wr_accept: got %b exp 1", ok); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 16'(16'h1111 * (i + 1));
            #1;
            tests_run++;
            if ({ram_load, ram_address, busy, done, rd_valid, cmd_ready} !== {1'b1, 3'(6 + i), 4'b1000}) begin
                tests_failed++;
                $display("FAIL wr_beat%0d: got load=%b addr=%0d busy=%b done=%b rv=%b rdy=%b exp 1 %0d 1 0 0 0",
                         i, ram_load, ram_address, busy, done, rd_valid, cmd_ready, 3'(6 + i));
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        tests_run++;
        if ({done, busy, cmd_ready, ram_load} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL wr_done: got done=%b busy=%b rdy=%b load=%b exp 1 0 1 0", done, busy, cmd_ready, ram_load);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL wr_done_pulse: got %b exp 0", done); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem[3'(6 + i)] !== 16'(16'h1111 * (i + 1))) begin
                tests_failed++;
                $display("FAIL wr_mem%0d: got %h exp %h", i, mem[3'(6 + i)], 16'(16'h1111 * (i + 1)));
            end
        end
    endtask

    task automatic test_read_burst();
        logic ok;
        logic exp_v;
        rd_ready = 1'b1;
        issue_cmd(1'b0, 3'd6, 3'd3, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL rd_accept: got %b exp 1", ok); end
        // Word k/3 is presented in cycles 3, 6, 9, 12 after the accept edge.
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            #1;
            exp_v = (k % 3 == 0) && (k <= 12);
            tests_run++;
            if (rd_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL rd_valid_c%0d: got %b exp %b", k, rd_valid, exp_v);
            end
            if (exp_v) begin
                tests_run++;
                if (rd_data !== 16'(16'h1111 * (k / 3))) begin
                    tests_failed++;
                    $display("FAIL rd_data_c%0d: got %h exp %h", k, rd_data, 16'(16'h1111 * (k / 3)));
                end
            end
            tests_run++;
            if ({ram_load, wr_ready, done} !== {2'b00, k == 13}) begin
                tests_failed++;
                $display("FAIL rd_ctrl_c%0d: got load=%b wrr=%b done=%b exp 0 0 %b", k, ram_load, wr_ready, done, k == 13);
            end
        end
    endtask

    task automatic test_read_stall();
        logic ok;
        logic seen_done;
        int idx, stall, nvalid;
        idx = 0; stall = 0; nvalid = 0; seen_done = 1'b0;
        rd_ready = 1'b1;
        issue_cmd(1'b0, 3'd6, 3'd3, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL stall_accept: got %b exp 1", ok); end
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge clk);
            #1;
            if (done) seen_done = 1'b1;
            if (rd_valid) begin
                nvalid++;
                tests_run++;
                if (rd_data !== 16'(16'h1111 * (idx + 1))) begin
                    tests_failed++;
                    $display("FAIL stall_data%0d: got %h exp %h", idx, rd_data, 16'(16'h1111 * (idx + 1)));
                end
                if (idx == 1 && stall < 5) begin
                    tests_run++;
                    if (ram_address !== 3'd7) begin
                        tests_failed++;
                        $display("FAIL stall_addr: got %0d exp 7", ram_address);
                    end
                    rd_ready = 1'b0;
                    stall++;
                end else begin
                    rd_ready = 1'b1;
                    idx++;
                end
            end
        end
        rd_ready = 1'b1;
        tests_run++;
        if ({seen_done, 3'(idx), 4'(nvalid)} !== {1'b1, 3'd4, 4'd9}) begin
            tests_failed++;
            $display("FAIL stall_totals: got done=%b words=%0d valid_cycles=%0d exp 1 4 9", seen_done, idx, nvalid);
        end
    endtask

    task automatic test_write_gaps();
        logic ok;
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        issue_cmd(1'b1, 3'd2, 3'd3, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL gap_accept: got %b exp 1", ok); end
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            wr_valid = pat[c % 4]; wr_data = 16'hA001 + 16'(k);
            cmd_valid = 1'b1; cmd_write = 1'b0;
            #1;
            tests_run++;
            if ({ram_load, ram_address, cmd_ready} !== {wr_valid, 3'(2 + k), 1'b0}) begin
                tests_failed++;
                $display("FAIL gap_c%0d: got load=%b addr=%0d rdy=%b exp %b %0d 0", c, ram_load, ram_address, cmd_ready, wr_valid, 3'(2 + k));
            end
            if (wr_valid) k++;
        end
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b0;
        #1;
        tests_run++;
        if ({done, cmd_ready, busy, 3'(k)} !== {3'b110, 3'd4}) begin
            tests_failed++;
            $display("FAIL gap_done: got done=%b rdy=%b busy=%b beats=%0d exp 1 1 0 4", done, cmd_ready, busy, k);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem[3'(2 + i)] !== 16'hA001 + 16'(i)) begin
                tests_failed++;
                $display("FAIL gap_mem%0d: got %h exp %h", i, mem[3'(2 + i)], 16'hA001 + 16'(i));
            end
        end
    endtask

    task automatic test_single_word();
        logic ok;
        logic got;
        int nload;
        nload = 0; got = 1'b0;
        issue_cmd(1'b1, 3'd7, 3'd0, ok);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 16'hBEEF;
            #1;
            if (ram_load) begin
                nload++;
                tests_run++;
                if (ram_address !== 3'd7) begin tests_failed++; $display("FAIL single_addr: got %0d exp 7", ram_address); end
            end
        end
        wr_valid = 1'b0;
        tests_run++;
        if ({ok, 2'(nload), mem[7]} !== {1'b1, 2'd1, 16'hBEEF}) begin
            tests_failed++;
            $display("FAIL single_write: got ok=%b loads=%0d mem7=%h exp 1 1 beef", ok, nload, mem[7]);
        end
        rd_ready = 1'b1;
        issue_cmd(1'b0, 3'd7, 3'd0, ok);
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            if (rd_valid) begin
                got = 1'b1;
                tests_run++;
                if (rd_data !== 16'hBEEF) begin tests_failed++; $display("FAIL single_rd_data: got %h exp beef", rd_data); end
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({ok, got, done} !== 3'b111) begin
            tests_failed++;
            $display("FAIL single_read: got ok=%b valid_seen=%b done=%b exp 1 1 1", ok, got, done);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic ok;
        logic got;
        int bad;
        got = 1'b0; bad = 0;
        issue_cmd(1'b1, 3'd0, 3'd3, ok);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 16'hC001 + 16'(i);
            #1;
            tests_run++;
            if (ram_load !== 1'b1) begin tests_failed++; $display("FAIL mid_beat%0d: got load=%b exp 1", i, ram_load); end
        end
        @(negedge clk);
        reset = 1'b1; wr_data = 16'hC003;
        #1;
        tests_run++;
        if ({ram_load, cmd_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_in_reset: got load=%b rdy=%b exp 0 0", ram_load, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({cmd_ready, busy, done, ram_load, wr_ready} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL mid_release: got rdy=%b busy=%b done=%b load=%b wrr=%b exp 1 0 0 0 0",
                     cmd_ready, busy, done, ram_load, wr_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (done || ram_load) bad++;
        end
        wr_valid = 1'b0;
        tests_run++;
        if ({4'(bad), mem[0], mem[1], mem[2]} !== {4'd0, 16'hC001, 16'hC002, 16'hA001}) begin
            tests_failed++;
            $display("FAIL mid_after: got stray=%0d mem0=%h mem1=%h mem2=%h exp 0 c001 c002 a001", bad, mem[0], mem[1], mem[2]);
        end
        rd_ready = 1'b1;
        issue_cmd(1'b0, 3'd1, 3'd0, ok);
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            if (rd_valid) begin
                got = 1'b1;
                tests_run++;
                if (rd_data !== 16'hC002) begin tests_failed++; $display("FAIL mid_rd_data: got %h exp c002", rd_data); end
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({ok, got, done} !== 3'b111) begin
            tests_failed++;
            $display("FAIL mid_new_cmd: got ok=%b valid_seen=%b done=%b exp 1 1 1", ok, got, done);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_stall();
        test_write_gaps();
        test_single_word();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
